// File: rtl/crc_serial_check.sv
// Receive-side serial CRC checker: runs the LSB-first LFSR over data plus FCS
// and reports pass/runt/bit-count when the frame strobe drops.
module crc_serial_check #(
    parameter int unsigned W   = 32,
    parameter logic [W-1:0] P  = W'(32'hEDB88320),
    parameter logic [W-1:0] R  = W'(32'hDEBB20E3),
    parameter int unsigned MIN = 40,
    parameter int unsigned CW  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame,
    input  logic          enable,
    input  logic          d,
    output logic          busy,
    output logic          done,
    output logic          ok,
    output logic          runt,
    output logic [CW-1:0] bits,
    output logic [W-1:0]  crc
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CW-1:0] COUNT_MAX = '1;

    state_t        state_q, state_d;
    logic [W-1:0]  crc_q, crc_d;
    logic [CW-1:0] count_q, count_d;
    logic          done_q, done_d;
    logic          ok_q, ok_d;
    logic          runt_q, runt_d;
    logic [CW-1:0] bits_q, bits_d;
    logic          busy_q, busy_d;
    logic          count_lt_min;

    function automatic logic [W-1:0] step(input logic [W-1:0] q, input logic b);
        step = (q >> 1) ^ ((q[0] ^ b) ? P : '0);
    endfunction

    always_comb begin
        count_lt_min = (32'(count_q) < MIN);
        state_d      = state_q;
        crc_d        = crc_q;
        count_d      = count_q;
        done_d       = 1'b0;
        ok_d         = ok_q;
        runt_d       = runt_q;
        bits_d       = bits_q;
        case (state_q)
            IDLE: begin
                crc_d   = {W{1'b1}};
                count_d = '0;
                if (frame && enable) begin
                    crc_d   = step({W{1'b1}}, d);
                    count_d = CW'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                // Frame end judges the register as it stood before this edge.
                if (!frame) begin
                    done_d  = 1'b1;
                    bits_d  = count_q;
                    runt_d  = count_lt_min;
                    ok_d    = (crc_q == R) && !count_lt_min;
                    crc_d   = {W{1'b1}};
                    count_d = '0;
                    state_d = IDLE;
                end else if (enable) begin
                    crc_d = step(crc_q, d);
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            crc_q   <= {W{1'b1}};
            count_q <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            runt_q  <= 1'b0;
            bits_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            count_q <= count_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            runt_q  <= runt_d;
            bits_q  <= bits_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ok   = ok_q;
    assign runt = runt_q;
    assign bits = bits_q;
    assign crc  = crc_q;

endmodule

// File: tb/tb_crc_serial_check.sv
// Scoreboard bench for crc_serial_check: stimulus pushes expected frame
// results, negedge monitors pop and compare whenever done pulses.
module tb_crc_serial_check;

    typedef struct {
        logic        ok;
        logic        runt;
        logic [15:0] bits;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame, enable, d;
    logic        busy, done, ok, runt;
    logic [15:0] bits;
    logic [31:0] crc;

    logic        frame2, enable2, d2;
    logic        busy2, done2, ok2, runt2;
    logic [3:0]  bits2;
    logic [31:0] crc2;

    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q_main[$];
    exp_t q_sat[$];

    logic [7:0] good_bytes [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                                    8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

    crc_serial_check dut (
        .clk(clk), .reset(reset), .frame(frame), .enable(enable), .d(d),
        .busy(busy), .done(done), .ok(ok), .runt(runt), .bits(bits), .crc(crc)
    );

    crc_serial_check #(.CW(4)) dut_sat (
        .clk(clk), .reset(reset), .frame(frame2), .enable(enable2), .d(d2),
        .busy(busy2), .done(done2), .ok(ok2), .runt(runt2), .bits(bits2), .crc(crc2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, then drop enable.
    task automatic applyStimulus(input logic f, input logic e, input logic b);
        frame  = f;
        enable = e;
        d      = b;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic endFrame(input logic eok, input logic erunt, input logic [15:0] ebits);
        exp_t e;
        e.ok   = eok;
        e.runt = erunt;
        e.bits = ebits;
        e.cyc  = cycle + 1;
        q_main.push_back(e);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("crc_restart", crc, 32'hFFFFFFFF);
        checkOutput("busy_after_end", {31'b0, busy}, 32'd0);
    endtask

    task automatic sendGood(input bit gap, input int flip);
        logic b;
        int   idx;
        for (int i = 0; i < 13; i++) begin
            for (int j = 0; j < 8; j++) begin
                idx = i * 8 + j;
                b   = good_bytes[i][j] ^ (idx == flip);
                if (gap && $urandom_range(0, 1) == 1) applyStimulus(1'b1, 1'b0, 1'($urandom));
                applyStimulus(1'b1, 1'b1, b);
                if (idx == 0) checkOutput("busy_in_frame", {31'b0, busy}, 32'd1);
                if (idx == 71 && flip < 0) checkOutput("crc_after_data", crc, 32'h340BC6D9);
            end
        end
        if (flip < 0) checkOutput("crc_residue", crc, 32'hDEBB20E3);
        if (flip < 0) endFrame(1'b1, 1'b0, 16'd104);
        else          endFrame(1'b0, 1'b0, 16'd104);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (q_main.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q_main.pop_front();
                checkOutput("done_cycle", cycle, e.cyc);
                checkOutput("ok", {31'b0, ok}, {31'b0, e.ok});
                checkOutput("runt", {31'b0, runt}, {31'b0, e.runt});
                checkOutput("bits", {16'b0, bits}, {16'b0, e.bits});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done2 === 1'b1) begin
            if (q_sat.size() == 0) begin
                checkOutput("sat_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q_sat.pop_front();
                checkOutput("sat_done_cycle", cycle, e.cyc);
                checkOutput("sat_ok", {31'b0, ok2}, {31'b0, e.ok});
                checkOutput("sat_runt", {31'b0, runt2}, {31'b0, e.runt});
                checkOutput("sat_bits", {28'b0, bits2}, {16'b0, e.bits});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        logic [7:0] runt_byte;
        reset = 1'b1;
        frame = 1'b0; enable = 1'b0; d = 1'b0;
        frame2 = 1'b0; enable2 = 1'b0; d2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_crc", crc, 32'hFFFFFFFF);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_ok_runt_bits", {15'b0, ok, runt, bits}, 32'd0);
        reset = 1'b0;

        $display("[TB] good frame");
        sendGood(1'b0, -1);

        $display("[TB] corrupt frame");
        sendGood(1'b0, 5);

        $display("[TB] runt frame 'hA5");
        runt_byte = 8'hA5;
        for (int j = 0; j < 8; j++) applyStimulus(1'b1, 1'b1, runt_byte[j]);
        endFrame(1'b0, 1'b1, 16'd8);

        $display("[TB] runt frame with matching residue");
        for (int j = 0; j < 32; j++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("runt_residue", crc, 32'hDEBB20E3);
        endFrame(1'b0, 1'b1, 16'd32);

        $display("[TB] gapped back-to-back frames");
        sendGood(1'b1, -1);
        sendGood(1'b1, -1);

        $display("[TB] reset mid-frame");
        for (int idx = 0; idx < 40; idx++) applyStimulus(1'b1, 1'b1, good_bytes[idx / 8][idx % 8]);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        frame = 1'b0;
        checkOutput("abort_ok_runt_bits", {15'b0, ok, runt, bits}, 32'd0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_crc", crc, 32'hFFFFFFFF);
        applyStimulus(1'b0, 1'b0, 1'b0);
        sendGood(1'b0, -1);

        $display("[TB] empty frame and idle enables");
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("empty_busy", {31'b0, busy}, 32'd0);
        checkOutput("empty_crc", crc, 32'hFFFFFFFF);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("idle_enable_crc", crc, 32'hFFFFFFFF);
        checkOutput("idle_enable_busy", {31'b0, busy}, 32'd0);

        $display("[TB] saturation with CW=4");
        for (int k = 0; k < 20; k++) begin
            frame2 = 1'b1; enable2 = 1'b1; d2 = 1'($urandom);
            @(posedge clk);
            #1;
        end
        frame2 = 1'b0; enable2 = 1'b0;
        e.ok = 1'b0; e.runt = 1'b1; e.bits = 16'd15; e.cyc = cycle + 1;
        q_sat.push_back(e);
        @(posedge clk);
        #1;

        repeat (4) @(posedge clk);
        #1;
        if (q_main.size() != 0) checkOutput("pending_done", q_main.size(), 32'd0);
        if (q_sat.size() != 0)  checkOutput("sat_pending_done", q_sat.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
